// File: rtl/srl_ser_pkg.sv
// Shared types for the PISO serializer.
// State encoding and counter sizing helper.
package srl_ser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/srl_ser_hold.sv
// One-entry valid/ready skid for the serializer input.
// Ready is its own flop so s_valid never reaches it combinationally.
module srl_ser_hold #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             take,
  output logic             full,
  output logic [WIDTH-1:0] data
);

  logic ready;

  assign s_ready = ready;

  // take needs full, accept needs !full: they cannot coincide
  always_ff @(posedge clk) begin
    if (rst) begin
      full  <= 1'b0;
      ready <= 1'b1;
      data  <= '0;
    end else if (take) begin
      full  <= 1'b0;
      ready <= 1'b1;
    end else if (s_valid && ready) begin
      full  <= 1'b1;
      ready <= 1'b0;
      data  <= s_data;
    end
  end

endmodule

// File: rtl/srl_piso_serializer.sv
// Word-to-bit serializer with per-bit valid and SOF/EOF framing.
// The serial side advances only on enabled edges.
module srl_piso_serializer
  import srl_ser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             e,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             q,
  output logic             q_valid,
  output logic             sof,
  output logic             eof,
  output logic             busy
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    idx;
  logic [WIDTH-1:0] shifter;
  logic [WIDTH-1:0] hold;
  logic             full;
  logic             last;
  logic             take;

  assign last = (cnt == LAST);
  assign idx  = MSB_FIRST ? (LAST - cnt) : cnt;

  // idle loads ignore e; mid-stream reload only on the last enabled bit
  assign take = full &&
    ((state == IDLE) || (state == SHIFT && e && last));

  assign busy = full || (state == SHIFT);

  srl_ser_hold #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk    (clk),
    .rst    (rst),
    .s_data (s_data),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .take   (take),
    .full   (full),
    .data   (hold)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      shifter <= '0;
      q       <= 1'b0;
      q_valid <= 1'b0;
      sof     <= 1'b0;
      eof     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (e) begin
            q       <= 1'b0;
            q_valid <= 1'b0;
            sof     <= 1'b0;
            eof     <= 1'b0;
          end
          if (full) begin
            shifter <= hold;
            cnt     <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (e) begin
            q       <= shifter[idx];
            q_valid <= 1'b1;
            sof     <= (cnt == '0);
            eof     <= last;
            if (!last) begin
              cnt <= cnt + 1'b1;
            end else if (full) begin
              shifter <= hold;
              cnt     <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_srl_piso_serializer.sv
// Bench for srl_piso_serializer: scoreboard of expected bits,
// SIPO loopback, and an LSB-first instance.
module tb_srl_piso_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       e = 1'b0;
  logic [7:0] s_data = '0;
  logic       s_valid = 1'b0;
  logic       s_ready, q, q_valid, sof, eof, busy;

  logic [7:0] s_data2 = '0;
  logic       s_valid2 = 1'b0;
  logic       s_ready2, q2, q_valid2, sof2, eof2, busy2;

  int n_vec = 0;
  int n_err = 0;
  int rec_cnt = 0;

  typedef struct {
    logic b;
    logic sf;
    logic ef;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] words[$];
  logic [7:0] sipo = '0;
  logic       e_at, rst_at;
  logic [3:0] prev;
  exp_t       ex;
  logic [7:0] wexp;

  always #5 clk = ~clk;

  srl_piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .e(e),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .q(q), .q_valid(q_valid), .sof(sof), .eof(eof), .busy(busy)
  );

  srl_piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .e(e),
    .s_data(s_data2), .s_valid(s_valid2), .s_ready(s_ready2),
    .q(q2), .q_valid(q_valid2), .sof(sof2), .eof(eof2), .busy(busy2)
  );

  // expected bits are queued at accept time
  always @(posedge clk) begin
    e_at   <= e;
    rst_at <= rst;
    if (rst) begin
      sb.delete();
      words.delete();
    end else if (s_valid && s_ready) begin
      for (int i = 0; i < 8; i++)
        sb.push_back('{s_data[7-i], i == 0, i == 7});
      words.push_back(s_data);
    end
  end

  always @(negedge clk) begin
    if (rst_at === 1'b0 && e_at === 1'b1 && q_valid) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL sb_underflow q_valid=%b want no bit", q_valid);
      end else begin
        ex = sb.pop_front();
        if ({q, sof, eof} !== {ex.b, ex.sf, ex.ef}) begin
          n_err++;
          $display("FAIL sb_bit q/sof/eof=%b%b%b want %b%b%b",
                   q, sof, eof, ex.b, ex.sf, ex.ef);
        end
      end
      sipo = {sipo[6:0], q};
      if (eof) begin
        rec_cnt++;
        n_vec++;
        if (words.size() == 0) begin
          n_err++;
          $display("FAIL loop_word got=%h want none", sipo);
        end else begin
          wexp = words.pop_front();
          if (sipo !== wexp) begin
            n_err++;
            $display("FAIL loop_word got=%h want %h", sipo, wexp);
          end
        end
      end
    end else if (rst_at === 1'b0 && e_at === 1'b0) begin
      n_vec++;
      if ({q, q_valid, sof, eof} !== prev) begin
        n_err++;
        $display("FAIL frozen got=%b want %b",
                 {q, q_valid, sof, eof}, prev);
      end
    end
    prev = {q, q_valid, sof, eof};
  end

  task automatic send(input logic [7:0] w);
    int t = 0;
    while (!s_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    n_vec++;
    if (!s_ready) begin
      n_err++;
      $display("FAIL send_timeout s_ready=%b want 1", s_ready);
    end
    s_data  = w;
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    e = 1'b1;
    while ((busy || q_valid || sb.size() != 0) && t < 300) begin
      @(negedge clk);
      t++;
    end
    n_vec++;
    if (busy || q_valid || sb.size() != 0) begin
      n_err++;
      $display("FAIL drain busy=%b q_valid=%b left=%0d want 0 0 0",
               busy, q_valid, sb.size());
    end
  endtask

  task automatic test_reset();
    e = 1'b1;
    send(8'h5A);
    s_data  = 8'h77;
    s_valid = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({q, q_valid, sof, eof, busy, s_ready} !== 6'b000001) begin
      n_err++;
      $display("FAIL reset outs=%b want 000001",
               {q, q_valid, sof, eof, busy, s_ready});
    end
    rst     = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_a5();
    logic [7:0] w = 8'hA5;
    int n = 0;
    e = 1'b1;
    send(w);
    for (int k = 0; k < 20 && n < 8; k++) begin
      @(negedge clk);
      if (q_valid) begin
        n_vec++;
        if ({q, sof, eof} !== {w[7-n], n == 0, n == 7}) begin
          n_err++;
          $display("FAIL a5_bit%0d q/sof/eof=%b%b%b want %b%b%b", n,
                   q, sof, eof, w[7-n], n == 0, n == 7);
        end
        n++;
      end
    end
    @(negedge clk);
    n_vec++;
    if (n != 8 || q_valid !== 1'b0) begin
      n_err++;
      $display("FAIL a5_end bits=%0d q_valid=%b want 8 0", n, q_valid);
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int first = -1;
    int last = -1;
    e = 1'b1;
    send(8'h3C);
    send(8'hC3);
    for (int k = 0; k < 40; k++) begin
      if (q_valid) begin
        n++;
        if (first < 0) first = k;
        last = k;
        if (n <= 8) begin
          n_vec++;
          if (s_ready !== (n == 8)) begin
            n_err++;
            $display("FAIL b2b_ready bit%0d s_ready=%b want %b",
                     n, s_ready, n == 8);
          end
        end
      end
      @(negedge clk);
    end
    n_vec++;
    if (n != 16 || last - first != 15) begin
      n_err++;
      $display("FAIL b2b_run bits=%0d span=%0d want 16 16",
               n, last - first + 1);
    end
  endtask

  task automatic test_enable_toggle();
    int first = -1;
    int last = -1;
    for (int k = 0; k < 30; k++) begin
      e = k[0];
      if (k == 0) begin
        n_vec++;
        if (s_ready !== 1'b1) begin
          n_err++;
          $display("FAIL tog_ready0 s_ready=%b want 1", s_ready);
        end
        s_data  = 8'hF0;
        s_valid = 1'b1;
      end else begin
        s_valid = 1'b0;
      end
      if (k == 1) begin
        n_vec++;
        if (s_ready !== 1'b0) begin
          n_err++;
          $display("FAIL tog_accept s_ready=%b want 0", s_ready);
        end
      end
      if (q_valid && first < 0) first = k;
      if (q_valid && eof && last < 0) last = k;
      @(negedge clk);
    end
    n_vec++;
    if (first < 0 || last < 0 || last - first + 1 != 15) begin
      n_err++;
      $display("FAIL tog_span span=%0d want 15", last - first + 1);
    end
    e = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int n = 0;
    e = 1'b1;
    send(8'hFF);
    send(8'h12);
    for (int k = 0; k < 20; k++) begin
      if (q_valid) n++;
      if (n == 3) break;
      @(negedge clk);
    end
    n_vec++;
    if (n != 3 || s_ready !== 1'b0) begin
      n_err++;
      $display("FAIL rmid_pre bits=%0d s_ready=%b want 3 0", n, s_ready);
    end
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({q, q_valid, sof, eof, busy, s_ready} !== 6'b000001) begin
      n_err++;
      $display("FAIL rmid_outs outs=%b want 000001",
               {q, q_valid, sof, eof, busy, s_ready});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lsb_first();
    int n = 0;
    e = 1'b1;
    s_data2  = 8'h01;
    s_valid2 = 1'b1;
    @(negedge clk);
    s_valid2 = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (q_valid2 && n < 8) begin
        n_vec++;
        if ({q2, sof2, eof2} !== {n == 0, n == 0, n == 7}) begin
          n_err++;
          $display("FAIL lsb_bit%0d q/sof/eof=%b%b%b want %b%b%b", n,
                   q2, sof2, eof2, n == 0, n == 0, n == 7);
        end
        n++;
      end
    end
    n_vec++;
    if (n != 8) begin
      n_err++;
      $display("FAIL lsb_count bits=%0d want 8", n);
    end
  endtask

  task automatic test_loopback();
    int start = rec_cnt;
    bit done = 1'b0;
    fork
      begin
        for (int i = 0; i < 32; i++) send(8'($urandom()));
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          e = 1'($urandom_range(0, 1));
        end
        e = 1'b1;
      end
    join
    drain();
    n_vec++;
    if (rec_cnt - start != 32) begin
      n_err++;
      $display("FAIL loop_count got=%0d want 32", rec_cnt - start);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_a5();
    test_back_to_back();
    test_enable_toggle();
    drain();
    test_reset_mid();
    test_lsb_first();
    test_loopback();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
